// File: rtl/rvv_backend_dispatch_uop_sequencer_pkg.sv
// Shared types for the dispatch uop sequencer: uop descriptor, EEW encoding,
// sequencer state and the EEW-to-shift helper used for byte/element scaling.
package rvv_backend_dispatch_uop_sequencer_pkg;

  localparam int VLEN            = 128;
  localparam int VLENB           = VLEN / 8;
  localparam int UOP_INDEX_WIDTH = 3;
  localparam int VSTART_WIDTH    = 8;

  typedef enum logic [1:0] {
    EEW8     = 2'b00,
    EEW16    = 2'b01,
    EEW32    = 2'b10,
    EEW_RSVD = 2'b11
  } EEW_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } SEQ_STATE_e;

  typedef struct packed {
    logic [5:0]                 funct6;
    logic [4:0]                 vd_index;
    logic [4:0]                 vs1_index;
    logic [4:0]                 vs2_index;
    EEW_e                       vd_eew;
    EEW_e                       vs1_eew;
    EEW_e                       vs2_eew;
    logic                       vm;
    logic [VSTART_WIDTH-1:0]    vstart;
    logic [UOP_INDEX_WIDTH-1:0] uop_index;
  } UOP_INFO_t;

  // log2 of the element size in bytes; reserved encodings scale as bytes
  function automatic logic [1:0] eew_to_shift(EEW_e e);
    case (e)
      EEW32:   eew_to_shift = 2'd2;
      EEW16:   eew_to_shift = 2'd1;
      default: eew_to_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rvv_backend_dispatch_uop_sequencer_if.sv
// Handshake bundle between the instruction source, the uop sequencer and the
// downstream byte-type/operand stage. The sequencer uses the slave modport.
interface rvv_backend_dispatch_uop_sequencer_if;
  import rvv_backend_dispatch_uop_sequencer_pkg::*;

  logic                       inst_valid;
  logic                       inst_ready;
  UOP_INFO_t                  inst_uop_info;
  logic [UOP_INDEX_WIDTH-1:0] inst_uop_last;
  logic [VLEN-1:0]            inst_v0;

  logic                       uop_valid;
  logic                       uop_ready;
  UOP_INFO_t                  uop_info;
  logic                       uop_last;
  logic [VLEN-1:0]            uop_v0;

  modport master (
    output inst_valid, inst_uop_info, inst_uop_last, inst_v0, uop_ready,
    input  inst_ready, uop_valid, uop_info, uop_last, uop_v0
  );

  modport slave (
    input  inst_valid, inst_uop_info, inst_uop_last, inst_v0, uop_ready,
    output inst_ready, uop_valid, uop_info, uop_last, uop_v0
  );

endinterface

// File: rtl/rvv_backend_dispatch_eew_max.sv
// Widest EEW among vs1/vs2/vd and its log2 byte size. Shared with the
// byte-type block so both stages agree on element scaling.
module rvv_backend_dispatch_eew_max
  import rvv_backend_dispatch_uop_sequencer_pkg::*;
(
  input  EEW_e       vs1_eew,
  input  EEW_e       vs2_eew,
  input  EEW_e       vd_eew,
  output EEW_e       eew_max,
  output logic [1:0] eew_max_shift
);

  // numeric order of the encoding matches element width order
  always_comb begin
    eew_max = vd_eew;
    if (vs1_eew > eew_max) eew_max = vs1_eew;
    if (vs2_eew > eew_max) eew_max = vs2_eew;
    eew_max_shift = eew_to_shift(eew_max);
  end

endmodule

// File: rtl/rvv_backend_dispatch_uop_sequencer.sv
// Splits one decoded vector instruction into uops 0..last, one per handshake,
// each carrying the instruction template and a v0 snapshot. Accepts the next
// instruction on the final handshake so back-to-back instructions have no
// bubble. Flush returns to IDLE on the next edge.
// Optional build macro RVV_DISPATCH_SKIP_PRESTART_EN: uops lying entirely
// below vstart (other than the last) are skipped internally, one cycle each.
module rvv_backend_dispatch_uop_sequencer
  import rvv_backend_dispatch_uop_sequencer_pkg::*;
#(
  parameter int UOP_NUM_MAX = 8,
  parameter int VLENB_WIDTH = $clog2(VLENB)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  output logic busy,
  rvv_backend_dispatch_uop_sequencer_if.slave bus
);

`ifdef RVV_DISPATCH_SKIP_PRESTART_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam int                         CW       = UOP_INDEX_WIDTH;
  localparam logic [CW-1:0]              LAST_MAX = CW'(UOP_NUM_MAX - 1);
  localparam logic [CW:0]                NUM_MAX  = (CW+1)'(UOP_NUM_MAX);

  SEQ_STATE_e      state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   last_q, last_d;
  UOP_INFO_t       info_q, info_d;
  logic [VLEN-1:0] v0_q, v0_d;

  logic            issuing, is_last, skip, hs, accept;
  logic [CW-1:0]   last_clamped;
  EEW_e            eew_max;
  logic [1:0]      eew_max_shift;
  logic [7:0]      shamt;
  logic [15:0]     uop_end;
  logic            prestart;

  rvv_backend_dispatch_eew_max u_eew_max (
    .vs1_eew       (info_q.vs1_eew),
    .vs2_eew       (info_q.vs2_eew),
    .vd_eew        (info_q.vd_eew),
    .eew_max       (eew_max),
    .eew_max_shift (eew_max_shift)
  );

  assign issuing = (state_q == ISSUE);
  assign is_last = issuing && (idx_q == last_q);

  // first element index beyond this uop; a uop ending at or below vstart
  // has no body elements. A reserved EEW disables skipping.
  assign shamt    = 8'(VLENB_WIDTH) - {6'd0, eew_max_shift};
  assign uop_end  = (16'(idx_q) + 16'd1) << shamt;
  assign prestart = (eew_max != EEW_RSVD) && (uop_end <= 16'(info_q.vstart));
  assign skip     = SKIP_EN && issuing && prestart && !is_last;

  assign bus.uop_valid  = issuing && !skip;
  assign bus.uop_last   = is_last;
  assign bus.uop_v0     = v0_q;
  assign hs             = bus.uop_valid && bus.uop_ready;
  assign bus.inst_ready = !flush && (!issuing || (hs && is_last));
  assign accept         = bus.inst_valid && bus.inst_ready;
  assign busy           = issuing;

  assign last_clamped = ({1'b0, bus.inst_uop_last} >= NUM_MAX) ? LAST_MAX
                                                              : bus.inst_uop_last;

  // output uop: registered template with the live uop count substituted
  always_comb begin
    bus.uop_info           = info_q;
    bus.uop_info.uop_index = idx_q;
  end

  // next state: flush dominates, then accept / advance / finish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    info_d  = info_q;
    v0_d    = v0_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (!issuing) begin
      if (accept) begin
        state_d = ISSUE;
        idx_d   = '0;
        last_d  = last_clamped;
        info_d  = bus.inst_uop_info;
        v0_d    = bus.inst_v0;
      end
    end else if (skip) begin
      idx_d = idx_q + CW'(1);
    end else if (hs) begin
      if (!is_last) begin
        idx_d = idx_q + CW'(1);
      end else if (accept) begin
        idx_d  = '0;
        last_d = last_clamped;
        info_d = bus.inst_uop_info;
        v0_d   = bus.inst_v0;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
  end

  // state, counter and captured instruction; everything clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      info_q  <= '0;
      v0_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      info_q  <= info_d;
      v0_q    <= v0_d;
    end
  end

  // an accepted uop count beyond the counter range is a decoder bug
  always @(posedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready)
      assert ({1'b0, bus.inst_uop_last} < NUM_MAX);
  end

endmodule

// File: tb/tb_rvv_backend_dispatch_uop_sequencer.sv
// Scoreboard bench for the uop sequencer: accepted instructions are expanded
// into expected uops by a behavioural model; a monitor pops and compares on
// every output handshake. Directed scenarios plus a randomized phase.
module tb_rvv_backend_dispatch_uop_sequencer;
  import rvv_backend_dispatch_uop_sequencer_pkg::*;

  typedef struct {
    UOP_INFO_t       info;
    logic            last;
    logic [VLEN-1:0] v0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  bit   rand_mode = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  rvv_backend_dispatch_uop_sequencer_if bus();

  rvv_backend_dispatch_uop_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // model: uop i of an instruction is issued unless it lies wholly before
  // vstart (element count per register = VLENB / widest element bytes)
  task automatic push_inst(UOP_INFO_t t, logic [UOP_INDEX_WIDTH-1:0] l,
                           logic [VLEN-1:0] v);
    exp_t e;
`ifdef RVV_DISPATCH_SKIP_PRESTART_EN
    int bytes;
    int elems;
    bytes = 1;
    if ((1 << int'(t.vd_eew))  > bytes) bytes = 1 << int'(t.vd_eew);
    if ((1 << int'(t.vs1_eew)) > bytes) bytes = 1 << int'(t.vs1_eew);
    if ((1 << int'(t.vs2_eew)) > bytes) bytes = 1 << int'(t.vs2_eew);
    elems = VLENB / bytes;
`endif
    for (int i = 0; i <= int'(l); i++) begin
      bit issue;
      issue = 1'b1;
`ifdef RVV_DISPATCH_SKIP_PRESTART_EN
      if (i != int'(l) && (i + 1) * elems <= int'(t.vstart)) issue = 1'b0;
`endif
      if (issue) begin
        e.info           = t;
        e.info.uop_index = UOP_INDEX_WIDTH'(i);
        e.last           = (i == int'(l));
        e.v0             = v;
        exp_q.push_back(e);
      end
    end
  endtask

  // acceptance watcher: expand each accepted instruction into the queue
  initial forever begin
    @(negedge clk);
    if (!rst && bus.inst_valid && bus.inst_ready)
      push_inst(bus.inst_uop_info, bus.inst_uop_last, bus.inst_v0);
  end

  // monitor: compare every output handshake, drop leftovers on flush
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && bus.uop_valid && bus.uop_ready) begin
      if (exp_q.size() == 0) begin
        chk("uop_unexpected", VLEN'(1), VLEN'(0));
      end else begin
        e = exp_q.pop_front();
        chk("uop_info", VLEN'(bus.uop_info), VLEN'(e.info));
        chk("uop_last", VLEN'(bus.uop_last), VLEN'(e.last));
        chk("uop_v0", bus.uop_v0, e.v0);
      end
    end
    if (!rst && flush) exp_q.delete();
  end

  // random backpressure and flush during the random phase
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      bus.uop_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic UOP_INFO_t mk_info(EEW_e vd, logic [VSTART_WIDTH-1:0] vs);
    UOP_INFO_t t;
    t           = '0;
    t.funct6    = 6'h2a;
    t.vd_index  = 5'd3;
    t.vs2_index = 5'd8;
    t.vd_eew    = vd;
    t.vs1_eew   = EEW8;
    t.vs2_eew   = EEW8;
    t.vm        = 1'b1;
    t.vstart    = vs;
    t.uop_index = 3'd5;
    return t;
  endfunction

  function automatic logic [VLEN-1:0] rand_v0();
    return VLEN'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // hold inst_valid until accepted; returns 1 time unit after the accepting edge
  task automatic send_inst(UOP_INFO_t t, logic [UOP_INDEX_WIDTH-1:0] l,
                           logic [VLEN-1:0] v);
    bit acc;
    acc               = 1'b0;
    bus.inst_valid    = 1'b1;
    bus.inst_uop_info = t;
    bus.inst_uop_last = l;
    bus.inst_v0       = v;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      if (bus.inst_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.inst_valid = 1'b0;
    if (!acc) chk("inst_accept_timeout", VLEN'(0), VLEN'(1));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2000 && (busy || exp_q.size() != 0); n++) @(negedge clk);
    chk("drain_queue", VLEN'(exp_q.size()), VLEN'(0));
    chk("drain_busy", VLEN'(busy), VLEN'(0));
  endtask

  initial begin
    UOP_INFO_t       t;
    logic [VLEN-1:0] va, vb;
    int              n_issued, first;

    rst               = 1'b1;
    flush             = 1'b0;
    bus.uop_ready     = 1'b0;
    bus.inst_valid    = 1'b0;
    bus.inst_uop_info = '0;
    bus.inst_uop_last = '0;
    bus.inst_v0       = '0;
    #1;
    chk("rst_uop_valid", VLEN'(bus.uop_valid), VLEN'(0));
    chk("rst_busy", VLEN'(busy), VLEN'(0));
    chk("rst_inst_ready", VLEN'(bus.inst_ready), VLEN'(1));
    chk("rst_uop_last", VLEN'(bus.uop_last), VLEN'(0));
    chk("rst_uop_info", VLEN'(bus.uop_info), VLEN'(0));
    chk("rst_uop_v0", bus.uop_v0, VLEN'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // four uops, no backpressure: consecutive indices, last only at 3
    bus.uop_ready = 1'b1;
    send_inst(mk_info(EEW8, 8'd0), 3'd3, rand_v0());
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", VLEN'(bus.uop_valid), VLEN'(1));
      chk("t1_index", VLEN'(bus.uop_info.uop_index), VLEN'(k));
      chk("t1_last", VLEN'(bus.uop_last), VLEN'(k == 3));
    end
    @(negedge clk);
    chk("t1_idle_busy", VLEN'(busy), VLEN'(0));
    chk("t1_idle_ready", VLEN'(bus.inst_ready), VLEN'(1));
    chk("t1_idle_valid", VLEN'(bus.uop_valid), VLEN'(0));

    // backpressure: outputs hold at index 0, then advance on ready
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b0;
    t  = mk_info(EEW16, 8'd0);
    va = rand_v0();
    send_inst(t, 3'd1, va);
    t.uop_index = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", VLEN'(bus.uop_valid), VLEN'(1));
      chk("t2_hold_info", VLEN'(bus.uop_info), VLEN'(t));
      chk("t2_hold_v0", bus.uop_v0, va);
    end
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b1;
    @(negedge clk);
    chk("t2_index0", VLEN'(bus.uop_info.uop_index), VLEN'(0));
    @(negedge clk);
    chk("t2_index1", VLEN'(bus.uop_info.uop_index), VLEN'(1));
    chk("t2_last1", VLEN'(bus.uop_last), VLEN'(1));
    wait_idle();

    // back-to-back: B accepted on A's final handshake, no idle cycle
    @(posedge clk);
    #1;
    va = rand_v0();
    vb = rand_v0();
    send_inst(mk_info(EEW8, 8'd0), 3'd1, va);
    send_inst(mk_info(EEW32, 8'd0), 3'd0, vb);
    @(negedge clk);
    chk("t3_b_valid", VLEN'(bus.uop_valid), VLEN'(1));
    chk("t3_b_index", VLEN'(bus.uop_info.uop_index), VLEN'(0));
    chk("t3_b_v0", bus.uop_v0, vb);
    chk("t3_b_last", VLEN'(bus.uop_last), VLEN'(1));
    wait_idle();

    // flush at index 2 of eight; a simultaneous descriptor waits
    @(posedge clk);
    #1;
    send_inst(mk_info(EEW8, 8'd0), 3'd7, rand_v0());
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    vb                = rand_v0();
    flush             = 1'b1;
    bus.inst_valid    = 1'b1;
    bus.inst_uop_info = mk_info(EEW16, 8'd0);
    bus.inst_uop_last = 3'd1;
    bus.inst_v0       = vb;
    @(negedge clk);
    chk("t4_flush_index", VLEN'(bus.uop_info.uop_index), VLEN'(2));
    chk("t4_flush_inst_ready", VLEN'(bus.inst_ready), VLEN'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t4_after_valid", VLEN'(bus.uop_valid), VLEN'(0));
    chk("t4_after_busy", VLEN'(busy), VLEN'(0));
    chk("t4_after_ready", VLEN'(bus.inst_ready), VLEN'(1));
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    @(negedge clk);
    chk("t4_new_valid", VLEN'(bus.uop_valid), VLEN'(1));
    chk("t4_new_index", VLEN'(bus.uop_info.uop_index), VLEN'(0));
    chk("t4_new_v0", bus.uop_v0, vb);
    wait_idle();

    // asynchronous reset mid-instruction, checked before any clock edge
    @(posedge clk);
    #1;
    send_inst(mk_info(EEW8, 8'd0), 3'd7, rand_v0());
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", VLEN'(bus.uop_valid), VLEN'(0));
    chk("t5_rst_busy", VLEN'(busy), VLEN'(0));
    chk("t5_rst_ready", VLEN'(bus.inst_ready), VLEN'(1));
    chk("t5_rst_last", VLEN'(bus.uop_last), VLEN'(0));
    chk("t5_rst_info", VLEN'(bus.uop_info), VLEN'(0));
    chk("t5_rst_v0", bus.uop_v0, VLEN'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // vstart=9 with 32-bit elements: four elements per uop
    @(posedge clk);
    #1;
    send_inst(mk_info(EEW32, 8'd9), 3'd3, rand_v0());
    n_issued = 0;
    first    = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.uop_valid) begin
        if (first < 0) first = int'(bus.uop_info.uop_index);
        n_issued++;
      end
    end
`ifdef RVV_DISPATCH_SKIP_PRESTART_EN
    chk("t6_issued", VLEN'(n_issued), VLEN'(2));
    chk("t6_first", VLEN'(first), VLEN'(2));
`else
    chk("t6_issued", VLEN'(n_issued), VLEN'(4));
    chk("t6_first", VLEN'(first), VLEN'(0));
`endif
    wait_idle();

    // randomized instructions with random backpressure and flushes
    @(posedge clk);
    #1;
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      t         = UOP_INFO_t'($bits(UOP_INFO_t)'({$urandom, $urandom}));
      t.vd_eew  = EEW_e'(2'($urandom_range(0, 2)));
      t.vs1_eew = EEW_e'(2'($urandom_range(0, 2)));
      t.vs2_eew = EEW_e'(2'($urandom_range(0, 2)));
      t.vstart  = VSTART_WIDTH'($urandom_range(0, 40));
      send_inst(t, UOP_INDEX_WIDTH'($urandom_range(0, 7)), rand_v0());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    flush         = 1'b0;
    bus.uop_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
